// File: rtl/im_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : im_fetch_scheduler
// Description : Sequences item-memory lookups for the encoder. Accepts
//               (addr_a, addr_b) requests over valid/ready and drives the
//               item-memory address/control inputs. With dimensional
//               expansion on, it walks extend_count segments per request and
//               pulses extend_increment once per consumed beat.
// Revision    : 1.0 - initial release
// ============================================================================
module im_fetch_scheduler #(
  parameter int unsigned ImAddrWidth = 10,
  parameter int unsigned ExtCntWidth = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   cfg_extend_en_i,
  input  logic [ExtCntWidth-1:0] cfg_extend_count_i,
  input  logic                   cfg_port_a_cim_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [ImAddrWidth-1:0] req_addr_a_i,
  input  logic [ImAddrWidth-1:0] req_addr_b_i,
  output logic [ImAddrWidth-1:0] im_a_addr_o,
  output logic [ImAddrWidth-1:0] im_b_addr_o,
  output logic                   im_port_a_cim_o,
  output logic                   im_enable_o,
  output logic                   im_extend_en_o,
  output logic                   im_extend_inc_o,
  output logic [ExtCntWidth-1:0] im_extend_count_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ExtCntWidth-1:0] out_seg_o,
  output logic                   out_last_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [ExtCntWidth-1:0] SegOne = ExtCntWidth'(1);

  state_e                 state_q, state_d;
  logic [ImAddrWidth-1:0] addr_a_q, addr_b_q;
  logic                   port_a_cim_q;
  logic                   extend_q;
  logic [ExtCntWidth-1:0] count_q;
  logic [ExtCntWidth-1:0] seg_q;
  logic [ExtCntWidth-1:0] count_eff;
  logic                   in_issue;
  logic                   is_last;
  logic                   beat;
  logic                   accept;

  // Effective segment count for a new request: zero or expansion-off means one.
  always_comb begin
    count_eff = SegOne;
    if (cfg_extend_en_i && (cfg_extend_count_i != '0)) begin
      count_eff = cfg_extend_count_i;
    end
  end

  // Next-state and handshake decode; clear overrides everything and suppresses the beat.
  always_comb begin
    state_d         = state_q;
    in_issue        = (state_q == ISSUE);
    is_last         = in_issue && (seg_q == (count_q - SegOne));
    out_valid_o     = in_issue && !clr_i;
    beat            = out_valid_o && out_ready_i;
    req_ready_o     = !clr_i && (!in_issue || (out_ready_i && is_last));
    accept          = req_valid_i && req_ready_o;
    im_enable_o     = out_valid_o;
    im_extend_inc_o = beat && extend_q;
    out_last_o      = is_last;
    if (clr_i) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = ISSUE;
    end else if (beat && is_last) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture and segment stepping; a new accept on the last beat reloads directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      port_a_cim_q <= 1'b0;
      extend_q     <= 1'b0;
      count_q      <= '0;
      seg_q        <= '0;
    end else if (clr_i) begin
      seg_q <= '0;
    end else if (accept) begin
      addr_a_q     <= req_addr_a_i;
      addr_b_q     <= req_addr_b_i;
      port_a_cim_q <= cfg_port_a_cim_i;
      extend_q     <= cfg_extend_en_i;
      count_q      <= count_eff;
      seg_q        <= '0;
    end else if (beat) begin
      seg_q <= is_last ? '0 : (seg_q + SegOne);
    end
  end

  assign im_a_addr_o       = addr_a_q;
  assign im_b_addr_o       = addr_b_q;
  assign im_port_a_cim_o   = port_a_cim_q;
  assign im_extend_en_o    = extend_q;
  assign im_extend_count_o = count_q;
  assign out_seg_o         = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_fetch_scheduler
// Description : Self-checking bench for im_fetch_scheduler. A queue of pending
//               beats models the scheduler; a small item-memory offset
//               counter models the downstream expansion counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_fetch_scheduler;

  localparam int AW = 10;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clr_i;
  logic          cfg_extend_en_i;
  logic [CW-1:0] cfg_extend_count_i;
  logic          cfg_port_a_cim_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_a_i;
  logic [AW-1:0] req_addr_b_i;
  logic [AW-1:0] im_a_addr_o;
  logic [AW-1:0] im_b_addr_o;
  logic          im_port_a_cim_o;
  logic          im_enable_o;
  logic          im_extend_en_o;
  logic          im_extend_inc_o;
  logic [CW-1:0] im_extend_count_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] out_seg_o;
  logic          out_last_o;

  im_fetch_scheduler #(.ImAddrWidth(AW), .ExtCntWidth(CW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .clr_i              (clr_i),
    .cfg_extend_en_i    (cfg_extend_en_i),
    .cfg_extend_count_i (cfg_extend_count_i),
    .cfg_port_a_cim_i   (cfg_port_a_cim_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_a_i       (req_addr_a_i),
    .req_addr_b_i       (req_addr_b_i),
    .im_a_addr_o        (im_a_addr_o),
    .im_b_addr_o        (im_b_addr_o),
    .im_port_a_cim_o    (im_port_a_cim_o),
    .im_enable_o        (im_enable_o),
    .im_extend_en_o     (im_extend_en_o),
    .im_extend_inc_o    (im_extend_inc_o),
    .im_extend_count_o  (im_extend_count_o),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .out_seg_o          (out_seg_o),
    .out_last_o         (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: list of beats still owed for the request in flight.
  typedef struct {
    int seg;
    bit last;
  } beat_t;

  beat_t q[$];
  int    held_a, held_b, held_cnt;
  bit    held_cim, held_ext;
  int    im_off;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observed DUT statistics for directed scenarios.
  int beats, incs, lasts, last_seg, first_a, first_b, first_seg, first_off, last_beat_cyc;
  bit have_first;
  bit s_valid, s_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    beats = 0; incs = 0; lasts = 0; last_seg = -1;
    first_a = -1; first_b = -1; first_seg = -1; first_off = -1;
    have_first = 0; last_beat_cyc = -1;
  endtask

  task automatic model_reset();
    q.delete();
    held_a = 0; held_b = 0; held_cnt = 0; held_cim = 0; held_ext = 0;
    im_off = 0;
  endtask

  // One clock cycle: drive inputs, compare against model, then advance model.
  task automatic step(input bit v, input int a, input int b, input bit ee, input int cnt,
                      input bit cim, input bit ordy, input bit cl);
    bit busy, exp_valid, exp_ready, acc, pop, s_inc;
    int exp_seg, ncnt, s_cnt;
    bit exp_last;
    @(negedge clk_i);
    req_valid_i        = v;
    req_addr_a_i       = a[AW-1:0];
    req_addr_b_i       = b[AW-1:0];
    cfg_extend_en_i    = ee;
    cfg_extend_count_i = cnt[CW-1:0];
    cfg_port_a_cim_i   = cim;
    out_ready_i        = ordy;
    clr_i              = cl;
    #1;
    busy      = (q.size() > 0);
    exp_valid = busy && !cl;
    exp_ready = !cl && (!busy || (ordy && q[0].last));
    acc       = v && exp_ready;
    pop       = exp_valid && ordy;
    exp_seg   = busy ? q[0].seg : 0;
    exp_last  = busy ? q[0].last : 1'b0;
    chk("req_ready", req_ready_o, exp_ready);
    chk("out_valid", out_valid_o, exp_valid);
    chk("im_enable", im_enable_o, exp_valid);
    chk("extend_inc", im_extend_inc_o, pop && held_ext);
    chk("a_addr", im_a_addr_o, held_a);
    chk("b_addr", im_b_addr_o, held_b);
    chk("port_a_cim", im_port_a_cim_o, held_cim);
    chk("extend_en", im_extend_en_o, held_ext);
    chk("extend_count", im_extend_count_o, held_cnt);
    chk("seg", out_seg_o, exp_seg);
    chk("last", out_last_o, exp_last);
    if (out_valid_o) chk("im_offset", im_off, out_seg_o);
    if (out_valid_o && out_ready_i) begin
      beats++;
      last_beat_cyc = cyc;
      if (!have_first) begin
        have_first = 1; first_a = im_a_addr_o; first_b = im_b_addr_o;
        first_seg = out_seg_o; first_off = im_off;
      end
      if (out_last_o) begin lasts++; last_seg = out_seg_o; end
    end
    if (im_extend_inc_o) incs++;
    s_valid = out_valid_o; s_en = im_enable_o; s_inc = im_extend_inc_o;
    s_cnt   = im_extend_count_o;
    @(posedge clk_i);
    if (!s_en) im_off = 0;
    else if (s_inc) im_off = (im_off + 1 >= s_cnt) ? 0 : im_off + 1;
    if (cl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        ncnt = (ee && cnt != 0) ? cnt : 1;
        for (int s = 0; s < ncnt; s++) q.push_back('{seg: s, last: (s == ncnt - 1)});
        held_a = a; held_b = b; held_cim = cim; held_ext = ee; held_cnt = ncnt;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic async_reset();
    @(negedge clk_i);
    req_valid_i = 0; clr_i = 0; out_ready_i = 0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_enable", im_enable_o, 0);
    chk("rst_seg", out_seg_o, 0);
    chk("rst_a_addr", im_a_addr_o, 0);
    chk("rst_count", im_extend_count_o, 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin : main
    int start;
    rst_ni = 1'b0; clr_i = 0; req_valid_i = 0; out_ready_i = 0;
    cfg_extend_en_i = 0; cfg_extend_count_i = '0; cfg_port_a_cim_i = 0;
    req_addr_a_i = '0; req_addr_b_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("reset_ready", req_ready_o, 1);
    chk("reset_valid", out_valid_o, 0);
    chk("reset_enable", im_enable_o, 0);
    chk("reset_b_addr", im_b_addr_o, 0);

    // Idle after reset: no beats, no increments.
    clear_stats();
    idle(20);
    chk("idle_beats", beats, 0);
    chk("idle_incs", incs, 0);

    // Expansion off, one beat at 5/9.
    clear_stats();
    step(1, 5, 9, 0, 3, 0, 1, 0);
    idle(3);
    chk("single_beats", beats, 1);
    chk("single_incs", incs, 0);
    chk("single_lasts", lasts, 1);
    chk("single_last_seg", last_seg, 0);
    chk("single_a", first_a, 5);
    chk("single_b", first_b, 9);

    // Count 4 with toggling out_ready; count changed to 7 mid-request.
    clear_stats();
    step(1, 100, 200, 1, 4, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 7, 0, (i % 2 == 0), 0);
    chk("ext4_beats", beats, 4);
    chk("ext4_incs", incs, 4);
    chk("ext4_lasts", lasts, 1);
    chk("ext4_last_seg", last_seg, 3);
    chk("ext4_a", first_a, 100);

    // Back-to-back: three count-2 requests, six beats in six cycles.
    clear_stats();
    start = cyc;
    for (int i = 0; i < 5; i++) step(1, 10 + i, 20 + i, 1, 2, 0, 1, 0);
    idle(4);
    chk("b2b_beats", beats, 6);
    chk("b2b_lasts", lasts, 3);
    chk("b2b_span", last_beat_cyc - start, 6);

    // Count 0 with expansion on behaves as count 1.
    clear_stats();
    step(1, 1, 2, 1, 0, 0, 1, 0);
    idle(3);
    chk("cnt0_beats", beats, 1);
    chk("cnt0_incs", incs, 1);
    chk("cnt0_lasts", lasts, 1);

    // Clear at segment 2 of a count-4 request.
    clear_stats();
    step(1, 50, 60, 1, 4, 0, 1, 0);
    step(0, 0, 0, 1, 4, 0, 1, 0);
    step(0, 0, 0, 1, 4, 0, 1, 0);
    step(0, 0, 0, 1, 4, 0, 1, 1);
    chk("clr_beats", beats, 2);
    chk("clr_incs", incs, 2);
    chk("clr_lasts", lasts, 0);
    clear_stats();
    step(1, 70, 80, 1, 4, 0, 1, 0);
    chk("post_clr_valid", s_valid, 0);
    chk("post_clr_enable", s_en, 0);
    idle(6);
    chk("post_clr_first_seg", first_seg, 0);
    chk("post_clr_first_off", first_off, 0);
    chk("post_clr_beats", beats, 4);
    chk("post_clr_a", first_a, 70);

    // Randomized traffic with one asynchronous reset mid-stream.
    for (int i = 0; i < 800; i++) begin
      int cnt;
      if (i == 400) async_reset();
      cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      step($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 1), cnt, $urandom_range(0, 1),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
